// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: queued LSU load/store/CAS initiator for the data scratchpad; CAS enabled by LSU_ATOMIC_EN
module lsu_mem_initiator #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4,
  parameter int QDEPTH = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_we,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic             req_atomic,
  input  logic [XLEN-1:0]  req_cmp,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_error,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [1:0]       mem_size,
  output logic             mem_atomic,
  output logic [XLEN-1:0]  mem_cmp_val,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_error,
  output logic             busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC);
`ifdef LSU_ATOMIC_EN
  localparam logic ATOM = 1'b1;
`else
  localparam logic ATOM = 1'b0;
`endif
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [1:0]       size;
    logic             uns;
    logic             atomic;
    logic [XLEN-1:0]  cmp;
  } op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  op_t fifo [QDEPTH];
  op_t head;
  state_t state;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop, head_bad, bad;
  logic [TAG_W-1:0] op_tag;
  logic [1:0] op_off, op_size;
  logic op_we, op_uns, op_atom;
  logic [CW-1:0] tcnt;
  assign req_ready = cnt != (AW+1)'(QDEPTH);
  assign push = req_valid && req_ready;
  assign pop = state == IDLE && cnt != '0;
  assign head = fifo[rp];
  assign busy = cnt != '0 || state != IDLE;
  // misaligned, reserved-size and disabled-atomic ops are answered locally without touching memory
  assign head_bad = head.size == 2'b11 || (head.size == 2'b10 && head.addr[1:0] != 2'b00) ||
                    (head.size == 2'b01 && head.addr[0]) || (head.atomic && !ATOM);
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = d[{op_off, 3'b000} +: 8];
    h = d[{op_off[1], 4'b0000} +: 16];
    return op_atom ? d : op_we ? '0 :
           op_size == 2'b00 ? {{(XLEN-8){b[7] & ~op_uns}}, b} :
           op_size == 2'b01 ? {{(XLEN-16){h[15] & ~op_uns}}, h} : d;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        fifo[wp] <= {req_tag, req_we, req_addr, req_wdata, req_size, req_unsigned, req_atomic, req_cmp};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bad <= 1'b0;
      tcnt <= '0;
      op_tag <= '0;
      op_off <= '0;
      op_size <= '0;
      op_we <= 1'b0;
      op_uns <= 1'b0;
      op_atom <= 1'b0;
      resp_valid <= 1'b0;
      resp_tag <= '0;
      resp_data <= '0;
      resp_error <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_size <= '0;
      mem_atomic <= 1'b0;
      mem_cmp_val <= '0;
    end else begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_size <= '0;
      mem_atomic <= 1'b0;
      mem_cmp_val <= '0;
      case (state)
        IDLE: if (pop) begin
          state <= ISSUE;
          bad <= head_bad;
          op_tag <= head.tag;
          op_off <= head.addr[1:0];
          op_size <= head.size;
          op_we <= head.we;
          op_uns <= head.uns;
          op_atom <= head.atomic;
          mem_req <= !head_bad;
          mem_we <= !head_bad && head.we;
          mem_addr <= head_bad ? '0 : head.addr;
          mem_wdata <= head_bad ? '0 : head.wdata;
          mem_size <= head_bad ? '0 : head.size;
          mem_atomic <= !head_bad && ATOM && head.atomic;
          mem_cmp_val <= (head_bad || !ATOM || !head.atomic) ? '0 : head.cmp;
        end
        ISSUE: if (bad || mem_error) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_tag <= op_tag;
          resp_data <= '0;
          resp_error <= 1'b1;
        end else begin
          state <= WAIT;
          tcnt <= '0;
        end
        WAIT: if (mem_ready || tcnt == CW'(TIMEOUT_CYC-1)) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_tag <= op_tag;
          resp_data <= mem_ready ? extract(mem_rdata) : '0;
          resp_error <= !mem_ready;
        end else tcnt <= tcnt + 1'b1;
        RESP: if (resp_ready) begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_tag <= '0;
          resp_data <= '0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: table-driven and sequence checks of lsu_mem_initiator against a scratchpad responder
module tb_lsu_mem_initiator;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_we = 0, req_unsigned = 0, req_atomic = 0, resp_ready = 0;
  logic req_ready, resp_valid, resp_error, mem_req, mem_we, mem_atomic, busy;
  logic [3:0] req_tag = 0, resp_tag;
  logic [31:0] req_addr = 0, req_wdata = 0, req_cmp = 0, resp_data, mem_addr, mem_wdata, mem_cmp_val;
  logic [1:0] req_size = 0, mem_size;
  logic mem_ready = 0, mem_error = 0;
  logic [31:0] mem_rdata = 0;
  int total = 0, bad = 0;
  logic [31:0] sp_rdata = 0;
  logic sp_err = 0, stray = 0;
  int sp_delay = 0;
  int nreq = 0, pend = -1;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic last_atom = 0;
  typedef struct {
    logic [3:0] tag; logic we; logic [31:0] addr, wdata; logic [1:0] size; logic uns, atom;
    logic [31:0] cmp, rdata; logic merr; int nreq; logic matom; logic [31:0] data; logic err; int lat;
  } vec_t;
  vec_t tv [15];
  lsu_mem_initiator dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_atomic(req_atomic), .req_cmp(req_cmp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_error(resp_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_atomic(mem_atomic), .mem_cmp_val(mem_cmp_val),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy)
  );
  always #5 clk = ~clk;
  // scratchpad model: error in the request cycle, completion sp_delay+1 cycles later, optional stray ready
  initial forever begin
    @(negedge clk);
    mem_ready = 0;
    mem_error = 0;
    if (pend == 0) begin mem_ready = 1; mem_rdata = sp_rdata; end
    if (pend >= 0) pend--;
    if (stray) begin mem_ready = 1; mem_rdata = 32'hBAD0BAD0; end
    if (mem_req) begin
      nreq++;
      last_addr = mem_addr;
      last_wdata = mem_wdata;
      last_atom = mem_atomic;
      mem_error = sp_err;
      pend = (sp_err || sp_delay < 0) ? -1 : sp_delay;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic push(input vec_t v);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_tag = v.tag; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; req_atomic = v.atom; req_cmp = v.cmp;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("push_timeout", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic get_resp(input string nm, input logic [3:0] t, input logic [31:0] d, input logic e, input int lat);
    int n = 0;
    logic [31:0] held;
    resp_ready = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 60);
    chk({nm, "_valid"}, 32'(resp_valid), 1);
    if (!resp_valid) return;
    chk({nm, "_tag"}, 32'(resp_tag), 32'(t));
    chk({nm, "_data"}, resp_data, d);
    chk({nm, "_err"}, 32'(resp_error), 32'(e));
    if (lat != 0) chk({nm, "_lat"}, 32'(n), 32'(lat));
    held = resp_data;
    @(negedge clk);
    chk({nm, "_hold"}, {31'b0, resp_valid} + resp_data, 1 + held);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
    chk({nm, "_drop"}, 32'(resp_valid), 0);
  endtask
  initial begin
    vec_t tmp;
    int base, next_tag;
    logic a;
    tv[0]  = '{4'h3, 1, 32'h100, 32'hDEADBEEF, 2, 0, 0, 0, 0,            0, 1, 0, 32'h0,        0, 4};
    tv[1]  = '{4'h1, 0, 32'h103, 0,            0, 0, 0, 0, 32'h80FF0000, 0, 1, 0, 32'hFFFFFF80, 0, 4};
    tv[2]  = '{4'h2, 0, 32'h103, 0,            0, 1, 0, 0, 32'h80FF0000, 0, 1, 0, 32'h00000080, 0, 4};
    tv[3]  = '{4'h4, 0, 32'h102, 0,            1, 0, 0, 0, 32'h80FF0000, 0, 1, 0, 32'hFFFF80FF, 0, 4};
    tv[4]  = '{4'h5, 0, 32'h101, 0,            1, 0, 0, 0, 32'h80FF0000, 0, 0, 0, 32'h0,        1, 3};
    tv[5]  = '{4'h6, 0, 32'h100, 0,            3, 0, 0, 0, 32'h80FF0000, 0, 0, 0, 32'h0,        1, 3};
    tv[6]  = '{4'h7, 0, 32'h106, 0,            2, 0, 0, 0, 32'h80FF0000, 0, 0, 0, 32'h0,        1, 3};
    tv[7]  = '{4'h8, 0, 32'h200, 0,            2, 0, 0, 0, 32'h12345678, 0, 1, 0, 32'h12345678, 0, 4};
    tv[8]  = '{4'h9, 0, 32'h100, 0,            1, 1, 0, 0, 32'h1234ABCD, 0, 1, 0, 32'h0000ABCD, 0, 4};
    tv[9]  = '{4'hA, 0, 32'h100, 0,            1, 0, 0, 0, 32'h1234ABCD, 0, 1, 0, 32'hFFFFABCD, 0, 4};
    tv[10] = '{4'hB, 0, 32'h101, 0,            0, 0, 0, 0, 32'h00007F00, 0, 1, 0, 32'h0000007F, 0, 4};
    tv[11] = '{4'hC, 1, 32'h300, 32'h11223344, 2, 0, 0, 0, 0,            1, 1, 0, 32'h0,        1, 3};
    tv[12] = '{4'hD, 1, 32'h101, 32'hAB,       0, 0, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 4};
`ifdef LSU_ATOMIC_EN
    tv[13] = '{4'hE, 0, 32'h100, 0,            2, 0, 1, 0,            0,            0, 1, 1, 32'h0,        0, 4};
    tv[14] = '{4'hF, 0, 32'h104, 32'h12345678, 2, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D, 0, 4};
`else
    tv[13] = '{4'hE, 0, 32'h100, 0,            2, 0, 1, 0,            0,            0, 0, 0, 32'h0,        1, 3};
    tv[14] = '{4'hF, 0, 32'h104, 32'h12345678, 2, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1, 3};
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_data", resp_data, 0);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      base = nreq;
      sp_rdata = tv[i].rdata;
      sp_err = tv[i].merr;
      push(tv[i]);
      get_resp($sformatf("v%0d", i), tv[i].tag, tv[i].data, tv[i].err, tv[i].lat);
      chk($sformatf("v%0d_nreq", i), 32'(nreq - base), 32'(tv[i].nreq));
      if (tv[i].nreq != 0) begin
        chk($sformatf("v%0d_maddr", i), last_addr, tv[i].addr);
        chk($sformatf("v%0d_mwdata", i), last_wdata, tv[i].wdata);
        chk($sformatf("v%0d_matom", i), 32'(last_atom), 32'(tv[i].matom));
      end
    end
    sp_rdata = 32'h0A0B0C0D;
    sp_err = 0;
    next_tag = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1; req_tag = 4'(next_tag); req_we = 0; req_addr = 32'h10; req_size = 2;
      req_unsigned = 0; req_atomic = 0;
      a = req_ready;
      @(posedge clk);
      #1 if (a) next_tag++;
    end
    req_valid = 0;
    @(negedge clk);
    chk("q_accepted", 32'(next_tag - 1), 5);
    chk("q_ready_low", 32'(req_ready), 0);
    chk("q_busy", 32'(busy), 1);
    for (int t = 1; t <= 5; t++) get_resp($sformatf("q%0d", t), 4'(t), 32'h0A0B0C0D, 0, 0);
    @(negedge clk);
    chk("q_idle", 32'(busy), 0);
    chk("q_ready_back", 32'(req_ready), 1);
    sp_delay = -1;
    tmp = tv[7];
    tmp.tag = 4'h9;
    tmp.addr = 32'h400;
    push(tmp);
    get_resp("tmo", 4'h9, 32'h0, 1, 19);
    sp_delay = 0;
    @(posedge clk);
    #1 stray = 1;
    @(posedge clk);
    #1 stray = 0;
    repeat (4) begin @(negedge clk); chk("stray_resp", 32'(resp_valid), 0); end
    chk("stray_busy", 32'(busy), 0);
    sp_rdata = 32'h0BADCAFE;
    tmp.tag = 4'h2;
    tmp.addr = 32'h404;
    push(tmp);
    get_resp("after", 4'h2, 32'h0BADCAFE, 0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
